// File: rtl/cpu_run_pkg.sv
// rtl/cpu_run_pkg.sv - shared states, exit encoding and trace entry layout for the run monitor
package cpu_run_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_RUN     = 2'd1;
    localparam state_t ST_HALTED  = 2'd2;
    localparam state_t ST_TIMEOUT = 2'd3;

    localparam logic [31:0] SYSCALL_WORD_DEFAULT = 32'h0000000C;

    // Trace entry is {pc, waddr, wdata}; wdata occupies the low bits.
    localparam int WADDR_WIDTH     = 5;
    localparam int TRACE_WDATA_LSB = 0;

    function automatic int trace_waddr_lsb(input int data_width);
        return data_width;
    endfunction

    function automatic int trace_pc_lsb(input int data_width);
        return data_width + WADDR_WIDTH;
    endfunction

endpackage

// File: rtl/cpu_run_monitor_trace_fifo.sv
// rtl/cpu_run_monitor_trace_fifo.sv - first-word fall-through FIFO with sync clear and drop-on-full strobe
module trace_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// rtl/cpu_run_monitor.sv - run control, end-of-program detection and retire trace beside the CPU
module cpu_run_monitor
    import cpu_run_pkg::*;
#(
    parameter int          PC_WIDTH     = 32,
    parameter int          DATA_WIDTH   = 32,
    parameter int          TRACE_DEPTH  = 16,
    parameter int          MAX_CYCLES   = 1000,
    parameter int          LOOP_REPEAT  = 3,
    parameter logic [31:0] SYSCALL_WORD = SYSCALL_WORD_DEFAULT
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               retire_valid,
    input  logic [PC_WIDTH-1:0]                pc,
    input  logic [31:0]                        instruction,
    input  logic                               reg_we,
    input  logic [4:0]                         reg_waddr,
    input  logic [DATA_WIDTH-1:0]              reg_wdata,
    output logic                               running,
    output logic                               halted,
    output logic                               timed_out,
    output logic [31:0]                        cycle_count,
    output logic [31:0]                        instr_count,
    input  logic                               trace_rd_en,
    output logic [PC_WIDTH+5+DATA_WIDTH-1:0]   trace_rd_data,
    output logic                               trace_empty,
    output logic [$clog2(TRACE_DEPTH):0]       trace_count,
    output logic                               trace_overflow
);

    localparam int ENTRY_WIDTH = PC_WIDTH + WADDR_WIDTH + DATA_WIDTH;
    localparam int PC_LSB      = trace_pc_lsb(DATA_WIDTH);
    localparam int WADDR_LSB   = trace_waddr_lsb(DATA_WIDTH);

    state_t                 state;
    logic [PC_WIDTH-1:0]    last_pc;
    logic [31:0]            repeat_cnt;
    logic [31:0]            next_repeat;
    logic                   start_run;
    logic                   exit_hit;
    logic                   timeout_hit;
    logic                   trace_push;
    logic                   fifo_overflow;
    logic [ENTRY_WIDTH-1:0] push_data;

    assign running   = (state == ST_RUN);
    assign start_run = start && (state != ST_RUN);

    // repeat_cnt==0 marks "no previous retire", so the first retire counts as 1.
    assign next_repeat = (repeat_cnt != 0 && pc == last_pc) ? repeat_cnt + 1'b1 : 32'd1;
    assign exit_hit    = running && retire_valid &&
                         (instruction == SYSCALL_WORD || next_repeat >= 32'(LOOP_REPEAT));
    assign timeout_hit = running && !exit_hit && (cycle_count == 32'(MAX_CYCLES - 1));
    assign trace_push  = running && retire_valid && reg_we && (reg_waddr != 5'd0);

    always_comb begin
        push_data = '0;
        push_data[PC_LSB +: PC_WIDTH]             = pc;
        push_data[WADDR_LSB +: WADDR_WIDTH]       = reg_waddr;
        push_data[TRACE_WDATA_LSB +: DATA_WIDTH]  = reg_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            cycle_count    <= '0;
            instr_count    <= '0;
            halted         <= 1'b0;
            timed_out      <= 1'b0;
            trace_overflow <= 1'b0;
            last_pc        <= '0;
            repeat_cnt     <= '0;
        end else if (start_run) begin
            state          <= ST_RUN;
            cycle_count    <= '0;
            instr_count    <= '0;
            halted         <= 1'b0;
            timed_out      <= 1'b0;
            trace_overflow <= 1'b0;
            last_pc        <= '0;
            repeat_cnt     <= '0;
        end else if (running) begin
            if (cycle_count != '1) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (retire_valid) begin
                if (instr_count != '1) begin
                    instr_count <= instr_count + 1'b1;
                end
                last_pc    <= pc;
                repeat_cnt <= next_repeat;
            end
            if (fifo_overflow) begin
                trace_overflow <= 1'b1;
            end
            if (exit_hit) begin
                state  <= ST_HALTED;
                halted <= 1'b1;
            end else if (timeout_hit) begin
                state     <= ST_TIMEOUT;
                timed_out <= 1'b1;
            end
        end
    end

    trace_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_run),
        .push      (trace_push),
        .push_data (push_data),
        .pop       (trace_rd_en),
        .rd_data   (trace_rd_data),
        .empty     (trace_empty),
        .count     (trace_count),
        .overflow  (fifo_overflow)
    );

endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb/tb_cpu_run_monitor.sv - directed vector table plus hand sequences for cpu_run_monitor
module tb_cpu_run_monitor;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] SYS = 32'h0000000C;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        retire_valid;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        running;
    logic        halted;
    logic        timed_out;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;
    logic        trace_rd_en;
    logic [68:0] trace_rd_data;
    logic        trace_empty;
    logic [2:0]  trace_count;
    logic        trace_overflow;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    cpu_run_monitor #(
        .PC_WIDTH     (32),
        .DATA_WIDTH   (32),
        .TRACE_DEPTH  (4),
        .MAX_CYCLES   (20),
        .LOOP_REPEAT  (3),
        .SYSCALL_WORD (SYS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .retire_valid   (retire_valid),
        .pc             (pc),
        .instruction    (instruction),
        .reg_we         (reg_we),
        .reg_waddr      (reg_waddr),
        .reg_wdata      (reg_wdata),
        .running        (running),
        .halted         (halted),
        .timed_out      (timed_out),
        .cycle_count    (cycle_count),
        .instr_count    (instr_count),
        .trace_rd_en    (trace_rd_en),
        .trace_rd_data  (trace_rd_data),
        .trace_empty    (trace_empty),
        .trace_count    (trace_count),
        .trace_overflow (trace_overflow)
    );

    typedef struct {
        logic        start;
        logic        rv;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        exp_run;
        logic        exp_halt;
        logic        exp_to;
        logic [31:0] exp_instr;
        logic [31:0] exp_cyc;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [31:0] p, input logic [31:0] ins,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic rd);
        retire_valid = rv;
        pc           = p;
        instruction  = ins;
        reg_we       = we;
        reg_waddr    = wa;
        reg_wdata    = wd;
        trace_rd_en  = rd;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic write_reg(input int k, input logic rd);
        drive(1'b1, 32'h200 + 32'(4 * k), NOP, 1'b1, 5'(k), 32'h11 * 32'(k), rd);
        tick();
    endtask

    function automatic logic [68:0] entry(input int k);
        return {32'h200 + 32'(4 * k), 5'(k), 32'h11 * 32'(k)};
    endfunction

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'd0,  NOP, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0};
        vecs[1]  = '{1'b0, 1'b1, 32'd0,  NOP, 1'b1, 1'b0, 1'b0, 32'd1, 32'd1};
        vecs[2]  = '{1'b0, 1'b1, 32'd4,  NOP, 1'b1, 1'b0, 1'b0, 32'd2, 32'd2};
        vecs[3]  = '{1'b0, 1'b1, 32'd8,  SYS, 1'b0, 1'b1, 1'b0, 32'd3, 32'd3};
        vecs[4]  = '{1'b0, 1'b1, 32'd12, NOP, 1'b0, 1'b1, 1'b0, 32'd3, 32'd3};
        vecs[5]  = '{1'b1, 1'b0, 32'd0,  NOP, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0};
        vecs[6]  = '{1'b0, 1'b1, 32'd0,  NOP, 1'b1, 1'b0, 1'b0, 32'd1, 32'd1};
        vecs[7]  = '{1'b0, 1'b1, 32'd4,  NOP, 1'b1, 1'b0, 1'b0, 32'd2, 32'd2};
        vecs[8]  = '{1'b0, 1'b1, 32'd8,  NOP, 1'b1, 1'b0, 1'b0, 32'd3, 32'd3};
        vecs[9]  = '{1'b0, 1'b1, 32'd8,  NOP, 1'b1, 1'b0, 1'b0, 32'd4, 32'd4};
        vecs[10] = '{1'b0, 1'b1, 32'd8,  NOP, 1'b0, 1'b1, 1'b0, 32'd5, 32'd5};
        vecs[11] = '{1'b1, 1'b0, 32'd0,  NOP, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0};
        vecs[12] = '{1'b0, 1'b1, 32'd8,  NOP, 1'b1, 1'b0, 1'b0, 32'd1, 32'd1};
        vecs[13] = '{1'b0, 1'b1, 32'd8,  NOP, 1'b1, 1'b0, 1'b0, 32'd2, 32'd2};
        vecs[14] = '{1'b0, 1'b1, 32'd4,  NOP, 1'b1, 1'b0, 1'b0, 32'd3, 32'd3};
        vecs[15] = '{1'b0, 1'b0, 32'd0,  NOP, 1'b1, 1'b0, 1'b0, 32'd3, 32'd4};
        vecs[16] = '{1'b1, 1'b0, 32'd0,  NOP, 1'b1, 1'b0, 1'b0, 32'd3, 32'd5};

        reset = 1'b1;
        start = 1'b0;
        drive(1'b0, 32'd0, NOP, 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        check("reset_running", running, 1'b0);
        check("reset_empty", trace_empty, 1'b1);
        check("reset_cycles", cycle_count, 32'd0);

        // Syscall exit, self-loop exit, non-halting 8,8,4 and start ignored in RUN.
        for (int i = 0; i < 17; i++) begin
            start = vecs[i].start;
            drive(vecs[i].rv, vecs[i].pc, vecs[i].ins, 1'b0, 5'd0, 32'd0, 1'b0);
            tick();
            start = 1'b0;
            check($sformatf("vec%0d_running", i), running, vecs[i].exp_run);
            check($sformatf("vec%0d_halted", i), halted, vecs[i].exp_halt);
            check($sformatf("vec%0d_timed_out", i), timed_out, vecs[i].exp_to);
            check($sformatf("vec%0d_instr", i), instr_count, vecs[i].exp_instr);
            check($sformatf("vec%0d_cycles", i), cycle_count, vecs[i].exp_cyc);
        end

        drive(1'b0, 32'd0, NOP, 1'b0, 5'd0, 32'd0, 1'b0);
        pulse_reset();
        check("rst2_running", running, 1'b0);
        check("rst2_instr", instr_count, 32'd0);
        check("rst2_cycles", cycle_count, 32'd0);

        // Timeout after exactly 20 RUN cycles.
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), NOP, 1'b0, 5'd0, 32'd0, 1'b0);
            tick();
            if (i == 18) begin
                check("to_cycle19_running", running, 1'b1);
                check("to_cycle19_count", cycle_count, 32'd19);
            end
        end
        check("to_timed_out", timed_out, 1'b1);
        check("to_running", running, 1'b0);
        check("to_halted", halted, 1'b0);
        check("to_cycles", cycle_count, 32'd20);
        drive(1'b0, 32'd0, NOP, 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        check("to_frozen", cycle_count, 32'd20);

        // Syscall in the final cycle beats the timeout.
        pulse_start();
        check("to_restart_flag", timed_out, 1'b0);
        check("to_restart_running", running, 1'b1);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), (i == 19) ? SYS : NOP, 1'b0, 5'd0, 32'd0, 1'b0);
            tick();
        end
        check("race_halted", halted, 1'b1);
        check("race_timed_out", timed_out, 1'b0);
        check("race_cycles", cycle_count, 32'd20);

        // Trace capture, $0 filtering and overflow.
        drive(1'b0, 32'd0, NOP, 1'b0, 5'd0, 32'd0, 1'b0);
        pulse_start();
        check("tr_restart_running", running, 1'b1);
        check("tr_restart_halted", halted, 1'b0);
        check("tr_restart_instr", instr_count, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            write_reg(k, 1'b0);
        end
        drive(1'b1, 32'h220, NOP, 1'b1, 5'd0, 32'hFF, 1'b0);
        tick();
        check("tr_count_full", trace_count, 3'd4);
        check("tr_overflow", trace_overflow, 1'b1);
        check("tr_instr", instr_count, 32'd7);
        drive(1'b0, 32'd0, NOP, 1'b0, 5'd0, 32'd0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("tr_pop%0d_data", k), trace_rd_data, entry(k));
            trace_rd_en = 1'b1;
            tick();
            trace_rd_en = 1'b0;
        end
        check("tr_drained_empty", trace_empty, 1'b1);
        trace_rd_en = 1'b1;
        tick();
        trace_rd_en = 1'b0;
        check("tr_pop_empty_count", trace_count, 3'd0);

        // Reset mid-run with 3 entries and cycle_count 7.
        pulse_reset();
        pulse_start();
        for (int k = 1; k <= 3; k++) begin
            write_reg(k, 1'b0);
        end
        drive(1'b0, 32'd0, NOP, 1'b0, 5'd0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check("mid_cycles", cycle_count, 32'd7);
        check("mid_count", trace_count, 3'd3);
        pulse_reset();
        check("mid_rst_running", running, 1'b0);
        check("mid_rst_cycles", cycle_count, 32'd0);
        check("mid_rst_empty", trace_empty, 1'b1);
        check("mid_rst_flags", {halted, timed_out, trace_overflow}, 3'b000);
        drive(1'b1, 32'h300, NOP, 1'b1, 5'd9, 32'h99, 1'b0);
        tick();
        check("idle_retire_instr", instr_count, 32'd0);
        check("idle_retire_count", trace_count, 3'd0);

        // Push and pop together at full.
        drive(1'b0, 32'd0, NOP, 1'b0, 5'd0, 32'd0, 1'b0);
        pulse_start();
        for (int k = 1; k <= 4; k++) begin
            write_reg(k, 1'b0);
        end
        check("pp_full_count", trace_count, 3'd4);
        check("pp_full_no_ovf", trace_overflow, 1'b0);
        write_reg(5, 1'b1);
        check("pp_count", trace_count, 3'd4);
        check("pp_no_ovf", trace_overflow, 1'b0);
        check("pp_head", trace_rd_data, entry(2));
        write_reg(6, 1'b0);
        check("pp_drop_ovf", trace_overflow, 1'b1);
        check("pp_drop_head", trace_rd_data, entry(2));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
